// File: rtl/ring_stats_collector.sv
// End-of-run statistics for the ring NoC: serially sums per-node counters, waits for full
// delivery or timeout, then divides total latency by total received. Option: RING_STATS_MINMAX_EN.
module ring_stats_collector #(
    parameter int NUM_NODES            = 8,
    parameter int CNT_W                = 64,
    parameter int NUM_PACKETS_PER_NODE = 20,
    parameter int TIMEOUT_CYCLES       = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_NODES*CNT_W-1:0] sent_flat,
    input  logic [NUM_NODES*CNT_W-1:0] recv_flat,
    input  logic [NUM_NODES*CNT_W-1:0] lat_flat,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [CNT_W-1:0]           sum_sent,
    output logic [CNT_W-1:0]           sum_recv,
    output logic [CNT_W-1:0]           sum_lat,
    output logic [CNT_W-1:0]           avg_lat,
    output logic [CNT_W-1:0]           drop_cnt
`ifdef RING_STATS_MINMAX_EN
    ,
    output logic [CNT_W-1:0]           min_recv,
    output logic [$clog2(NUM_NODES)-1:0] min_recv_node
`endif
);

    localparam int IDX_W = $clog2(NUM_NODES);
    localparam int DC_W  = $clog2(CNT_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_NODES - 1);
    localparam logic [CNT_W-1:0] EXPECTED    = CNT_W'(NUM_NODES * NUM_PACKETS_PER_NODE);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [DC_W-1:0]  DIV_STEPS   = DC_W'(CNT_W);

    typedef enum logic [1:0] {IDLE, SCAN, DIVIDE, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] acc_sent, acc_recv, acc_lat;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] quo, rem;
    logic [DC_W-1:0]  div_cnt;

    logic [CNT_W-1:0] sel_sent, sel_recv, sel_lat;
    logic [CNT_W-1:0] nxt_sent, nxt_recv, nxt_lat;
    logic             scan_last, recv_met, timed_out;
    logic [CNT_W-1:0] rem_shift, rem_next;
    logic             rem_ge;

    always_comb begin
        sel_sent  = sent_flat[idx*CNT_W +: CNT_W];
        sel_recv  = recv_flat[idx*CNT_W +: CNT_W];
        sel_lat   = lat_flat[idx*CNT_W +: CNT_W];
        nxt_sent  = acc_sent + sel_sent;
        nxt_recv  = acc_recv + sel_recv;
        nxt_lat   = acc_lat + sel_lat;
        scan_last = (idx == LAST_IDX);
        recv_met  = (nxt_recv >= EXPECTED);
        timed_out = (timer >= TIMEOUT_LIM);
    end

    // The shifted remainder is CNT_W+1 bits wide; its top bit is rem[CNT_W-1], and when set
    // the trial subtraction always succeeds, with the true difference fitting in CNT_W bits.
    always_comb begin
        rem_shift = {rem[CNT_W-2:0], quo[CNT_W-1]};
        rem_ge    = rem[CNT_W-1] || (rem_shift >= sum_recv);
        rem_next  = rem_ge ? (rem_shift - sum_recv) : rem_shift;
    end

`ifdef RING_STATS_MINMAX_EN
    logic [CNT_W-1:0] min_acc;
    logic [IDX_W-1:0] min_acc_idx;
    logic             min_take;

    // Strict less-than keeps the earliest node on ties.
    always_comb begin
        min_take = (idx == '0) || (sel_recv < min_acc);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            acc_sent <= '0;
            acc_recv <= '0;
            acc_lat  <= '0;
            timer    <= '0;
            quo      <= '0;
            rem      <= '0;
            div_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            sum_sent <= '0;
            sum_recv <= '0;
            sum_lat  <= '0;
            avg_lat  <= '0;
            drop_cnt <= '0;
`ifdef RING_STATS_MINMAX_EN
            min_acc       <= '0;
            min_acc_idx   <= '0;
            min_recv      <= '0;
            min_recv_node <= '0;
`endif
        end else begin
            if ((state == SCAN || state == DIVIDE) && timer != '1) begin
                timer <= timer + 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        timer    <= '0;
                        idx      <= '0;
                        acc_sent <= '0;
                        acc_recv <= '0;
                        acc_lat  <= '0;
                    end
                end

                SCAN: begin
                    if (!scan_last) begin
                        idx      <= idx + 1'b1;
                        acc_sent <= nxt_sent;
                        acc_recv <= nxt_recv;
                        acc_lat  <= nxt_lat;
`ifdef RING_STATS_MINMAX_EN
                        if (min_take) begin
                            min_acc     <= sel_recv;
                            min_acc_idx <= idx;
                        end
`endif
                    end else if (recv_met || timed_out) begin
                        state    <= DIVIDE;
                        timeout  <= !recv_met;
                        sum_sent <= nxt_sent;
                        sum_recv <= nxt_recv;
                        sum_lat  <= nxt_lat;
                        drop_cnt <= (nxt_sent >= nxt_recv) ? (nxt_sent - nxt_recv) : '0;
                        quo      <= nxt_lat;
                        rem      <= '0;
                        div_cnt  <= '0;
`ifdef RING_STATS_MINMAX_EN
                        min_recv      <= min_take ? sel_recv : min_acc;
                        min_recv_node <= min_take ? idx : min_acc_idx;
`endif
                    end else begin
                        // Incomplete delivery: restart the sweep straight away.
                        idx      <= '0;
                        acc_sent <= '0;
                        acc_recv <= '0;
                        acc_lat  <= '0;
                    end
                end

                DIVIDE: begin
                    if (div_cnt == DIV_STEPS) begin
                        state   <= DONE;
                        avg_lat <= (sum_recv == '0) ? '0 : quo;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        rem     <= rem_next;
                        quo     <= {quo[CNT_W-2:0], rem_ge};
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_stats_collector.sv
// Directed bench for ring_stats_collector: three instances differing only in TIMEOUT_CYCLES.
// Expected results come from a behavioural model and are queued when each run is started.
module tb_ring_stats_collector;

    localparam int N = 8;
    localparam int W = 64;

    typedef struct {
        logic [W-1:0] sum_sent;
        logic [W-1:0] sum_recv;
        logic [W-1:0] sum_lat;
        logic [W-1:0] avg_lat;
        logic [W-1:0] drop_cnt;
        logic         timeout;
        logic [W-1:0] min_recv;
        logic [W-1:0] min_node;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [N*W-1:0] sent_flat, recv_flat, lat_flat;
    logic [W-1:0] sent_v[N], recv_v[N], lat_v[N];

    logic a_busy, a_done, a_to, b_busy, b_done, b_to, c_busy, c_done, c_to;
    logic [W-1:0] a_ss, a_sr, a_sl, a_avg, a_drop;
    logic [W-1:0] b_ss, b_sr, b_sl, b_avg, b_drop;
    logic [W-1:0] c_ss, c_sr, c_sl, c_avg, c_drop;
`ifdef RING_STATS_MINMAX_EN
    logic [W-1:0] a_min, b_min, c_min;
    logic [2:0]   a_mn, b_mn, c_mn;
`endif

    res_t exp_q[$];
    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            sent_flat[i*W +: W] = sent_v[i];
            recv_flat[i*W +: W] = recv_v[i];
            lat_flat[i*W +: W]  = lat_v[i];
        end
    end

    ring_stats_collector #(.TIMEOUT_CYCLES(65535)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .sent_flat(sent_flat), .recv_flat(recv_flat), .lat_flat(lat_flat),
        .busy(a_busy), .done(a_done), .timeout(a_to),
        .sum_sent(a_ss), .sum_recv(a_sr), .sum_lat(a_sl), .avg_lat(a_avg), .drop_cnt(a_drop)
`ifdef RING_STATS_MINMAX_EN
        , .min_recv(a_min), .min_recv_node(a_mn)
`endif
    );

    ring_stats_collector #(.TIMEOUT_CYCLES(100)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .sent_flat(sent_flat), .recv_flat(recv_flat), .lat_flat(lat_flat),
        .busy(b_busy), .done(b_done), .timeout(b_to),
        .sum_sent(b_ss), .sum_recv(b_sr), .sum_lat(b_sl), .avg_lat(b_avg), .drop_cnt(b_drop)
`ifdef RING_STATS_MINMAX_EN
        , .min_recv(b_min), .min_recv_node(b_mn)
`endif
    );

    ring_stats_collector #(.TIMEOUT_CYCLES(20)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
        .sent_flat(sent_flat), .recv_flat(recv_flat), .lat_flat(lat_flat),
        .busy(c_busy), .done(c_done), .timeout(c_to),
        .sum_sent(c_ss), .sum_recv(c_sr), .sum_lat(c_sl), .avg_lat(c_avg), .drop_cnt(c_drop)
`ifdef RING_STATS_MINMAX_EN
        , .min_recv(c_min), .min_recv_node(c_mn)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_all(input int s, input int r, input int l);
        for (int i = 0; i < N; i++) begin
            sent_v[i] = W'(s);
            recv_v[i] = W'(r);
            lat_v[i]  = W'(l);
        end
    endtask

    function automatic res_t model(input logic to);
        res_t r;
        r.sum_sent = '0;
        r.sum_recv = '0;
        r.sum_lat  = '0;
        r.min_recv = recv_v[0];
        r.min_node = '0;
        for (int i = 0; i < N; i++) begin
            r.sum_sent += sent_v[i];
            r.sum_recv += recv_v[i];
            r.sum_lat  += lat_v[i];
            if (recv_v[i] < r.min_recv) begin
                r.min_recv = recv_v[i];
                r.min_node = W'(i);
            end
        end
        r.avg_lat  = (r.sum_recv == '0) ? '0 : r.sum_lat / r.sum_recv;
        r.drop_cnt = (r.sum_sent >= r.sum_recv) ? r.sum_sent - r.sum_recv : '0;
        r.timeout  = to;
        return r;
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic res_t observe(input int sel);
        res_t r;
        r.min_recv = '0;
        r.min_node = '0;
        case (sel)
            0: begin
                r.sum_sent = a_ss; r.sum_recv = a_sr; r.sum_lat = a_sl;
                r.avg_lat = a_avg; r.drop_cnt = a_drop; r.timeout = a_to;
`ifdef RING_STATS_MINMAX_EN
                r.min_recv = a_min; r.min_node = W'(a_mn);
`endif
            end
            1: begin
                r.sum_sent = b_ss; r.sum_recv = b_sr; r.sum_lat = b_sl;
                r.avg_lat = b_avg; r.drop_cnt = b_drop; r.timeout = b_to;
`ifdef RING_STATS_MINMAX_EN
                r.min_recv = b_min; r.min_node = W'(b_mn);
`endif
            end
            default: begin
                r.sum_sent = c_ss; r.sum_recv = c_sr; r.sum_lat = c_sl;
                r.avg_lat = c_avg; r.drop_cnt = c_drop; r.timeout = c_to;
`ifdef RING_STATS_MINMAX_EN
                r.min_recv = c_min; r.min_node = W'(c_mn);
`endif
            end
        endcase
        return r;
    endfunction

    task automatic pulse_start(input int sel);
        case (sel)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    // Returns cycles waited after the start edge, or -1 if the bound expires.
    task automatic wait_done(input int sel, input int max_cyc, output int n);
        n = 0;
        while (!get_done(sel) && n < max_cyc) begin
            tick();
            n++;
        end
        if (!get_done(sel)) n = -1;
    endtask

    task automatic score(input int sel, input string tag);
        res_t e, o;
        check({tag, "_exp_q_nonempty"}, W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observe(sel);
            check({tag, "_sum_sent"}, o.sum_sent, e.sum_sent);
            check({tag, "_sum_recv"}, o.sum_recv, e.sum_recv);
            check({tag, "_sum_lat"},  o.sum_lat,  e.sum_lat);
            check({tag, "_avg_lat"},  o.avg_lat,  e.avg_lat);
            check({tag, "_drop_cnt"}, o.drop_cnt, e.drop_cnt);
            check({tag, "_timeout"},  W'(o.timeout), W'(e.timeout));
`ifdef RING_STATS_MINMAX_EN
            check({tag, "_min_recv"}, o.min_recv, e.min_recv);
            check({tag, "_min_node"}, o.min_node, e.min_node);
`endif
        end
    endtask

    initial begin
        int n;
        set_all(20, 20, 100);

        // Reset state
        repeat (3) tick();
        check("rst_busy", W'(a_busy), W'(0));
        check("rst_done", W'(a_done | b_done | c_done), W'(0));
        check("rst_sum_sent", a_ss, W'(0));
        check("rst_avg_lat", a_avg, W'(0));
        rst_n = 1'b1;
        tick();

        // 1: full delivery, exact completion latency
        set_all(20, 20, 100);
        exp_q.push_back(model(1'b0));
        pulse_start(0);
        check("t1_busy_after_start", W'(a_busy), W'(1));
        wait_done(0, 200, n);
        check("t1_done_cycle", W'(n), W'(73));
        check("t1_busy_at_done", W'(a_busy), W'(0));
        score(0, "t1");
        repeat (5) tick();
        check("t1_done_held", W'(a_done), W'(1));

        // 5a: start during SCAN is ignored
        exp_q.push_back(model(1'b0));
        pulse_start(0);
        check("t5_done_cleared", W'(a_done), W'(0));
        tick();
        tick();
        pulse_start(0);
        wait_done(0, 200, n);
        check("t5_ignored_start_cycle", W'(n + 3), W'(73));
        score(0, "t5a");

        // 5b: reset mid-DIVIDE clears everything asynchronously
        pulse_start(0);
        repeat (40) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", W'(a_busy), W'(0));
        check("t5_rst_done", W'(a_done), W'(0));
        check("t5_rst_sum_sent", a_ss, W'(0));
        check("t5_rst_sum_recv", a_sr, W'(0));
        check("t5_rst_sum_lat", a_sl, W'(0));
        check("t5_rst_avg_lat", a_avg, W'(0));
        check("t5_rst_drop_cnt", a_drop, W'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // 2: stuck at 150 of 160 with a 100-cycle timeout
        set_all(20, 19, 100);
        recv_v[6] = 18;
        recv_v[7] = 18;
        exp_q.push_back(model(1'b1));
        pulse_start(1);
        repeat (73) tick();
        check("t2_rescanning", W'(b_done), W'(0));
        wait_done(1, 400, n);
        check("t2_done_seen", W'(n >= 0), W'(1));
        score(1, "t2");

        // 3: nothing received, divide-by-zero path
        set_all(20, 0, 0);
        exp_q.push_back(model(1'b1));
        pulse_start(2);
        wait_done(2, 400, n);
        check("t3_done_seen", W'(n >= 0), W'(1));
        score(2, "t3");

        // 4: received counts ramp up to full delivery over 300 cycles
        set_all(20, 0, 125);
        lat_v[0] = 126;
        for (int i = 0; i < N; i++) recv_v[i] = 20;
        exp_q.push_back(model(1'b0));
        for (int i = 0; i < N; i++) recv_v[i] = 0;
        pulse_start(0);
        for (int t = 1; t <= 300; t++) begin
            for (int i = 0; i < N; i++) recv_v[i] = W'((t * 20) / 300);
            tick();
            if (t == 250) check("t4_not_done_mid_ramp", W'(a_done), W'(0));
        end
        wait_done(0, 300, n);
        check("t4_done_seen", W'(n >= 0), W'(1));
        score(0, "t4");

        // 7: random counters, both drop polarities
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                sent_v[i] = W'($urandom_range(10, 40));
                recv_v[i] = W'($urandom_range(20, 35));
                lat_v[i]  = W'($urandom_range(0, 5000));
            end
            exp_q.push_back(model(1'b0));
            pulse_start(0);
            wait_done(0, 200, n);
            check("t7_done_cycle", W'(n), W'(73));
            score(0, "t7");
        end

`ifdef RING_STATS_MINMAX_EN
        // 6: minimum receiver with a tie between nodes 3 and 5
        set_all(20, 20, 100);
        recv_v[3] = 5;
        recv_v[5] = 5;
        exp_q.push_back(model(1'b1));
        pulse_start(2);
        wait_done(2, 400, n);
        check("t6_done_seen", W'(n >= 0), W'(1));
        score(2, "t6");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
